// File: rtl/conv_stream_tx_pkg.sv
// conv_tx_pkg: shared types and frame geometry for the convolution stream transmitter
package conv_tx_pkg;
  localparam int N_FILT = 10;
  localparam int N_PIX = 64;
  localparam int N_RES = 16;
  localparam int RES_W = 16;
  localparam int TIMEOUT = 128;
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int FRAME_WORDS = N_FILT + N_PIX;
  localparam int ROW_BASE = 0;
  localparam int COL_BASE = 5;
  localparam int PIX_BASE = 10;
  typedef enum logic [2:0] {IDLE, FILTER, IMAGE, COLLECT, FIN} state_t;
endpackage

// File: rtl/conv_stream_tx_if.sv
// conv_stream_tx_if: serial stream to the convolution engine and its result return path
interface conv_stream_tx_if;
  import conv_tx_pkg::*;
  logic filter_valid;
  logic image_valid;
  logic [3:0] in_data;
  logic out_valid;
  logic [RES_W-1:0] out_data;
  modport master(output filter_valid, image_valid, in_data, input out_valid, out_data);
  modport slave(input filter_valid, image_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/conv_stream_tx_result_bank.sv
// conv_tx_result_bank: 16-entry result store with frame clear, indexed write, combinational read
module conv_tx_result_bank
  import conv_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [RES_W-1:0] wdata,
  input  logic [3:0]       raddr,
  output logic [RES_W-1:0] rdata
);
  logic [RES_W-1:0] mem [N_RES];
  // clear wins over a write so a new frame always starts from an all-zero bank
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '{default: '0};
    else if (clr) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/conv_stream_tx.sv
// conv_stream_tx: serializes a filter+image frame to the engine and collects its results
// (CONV_TX_TIMEOUT_EN adds an abort counter and a sticky timeout_err flag)
module conv_stream_tx
  import conv_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [6:0]       wr_addr,
  input  logic [3:0]       wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_addr,
  output logic [RES_W-1:0] rd_data,
  output logic             timeout_err,
  conv_stream_tx_if.master s
);
  state_t state, state_n;
  logic [6:0] idx, idx_n;
  logic [4:0] beat;
  logic [3:0] fbuf [FRAME_WORDS];
  logic go, cap, last, tmo;
  logic fv_d, iv_d;
  logic [3:0] data_d;
  assign go = state == IDLE && start;
  assign cap = s.out_valid && (state == IMAGE || state == COLLECT) && beat < 5'(N_RES);
  assign last = cap && beat == 5'(N_RES - 1);
  assign busy = state != IDLE;
  assign done = state == FIN;
  // frame buffer: host writes only while idle, and never alongside an accepted start
  always_ff @(posedge clk)
    if (state == IDLE && wr_en && !start && wr_addr < 7'(FRAME_WORDS)) fbuf[wr_addr] <= wr_data;
  // state, word index, beat counter and registered stream outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      beat <= '0;
      s.filter_valid <= 1'b0;
      s.image_valid <= 1'b0;
      s.in_data <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      beat <= go ? 5'd0 : beat + 5'(cap);
      s.filter_valid <= fv_d;
      s.image_valid <= iv_d;
      s.in_data <= data_d;
    end
  // next state: idx is the buffer word shown on in_data during FILTER/IMAGE
  always_comb begin
    state_n = state;
    idx_n = idx;
    case (state)
      IDLE: begin
        idx_n = 7'(ROW_BASE);
        if (start) state_n = FILTER;
      end
      FILTER: begin
        idx_n = idx + 7'd1;
        if (idx == 7'(PIX_BASE - 1)) state_n = IMAGE;
      end
      IMAGE: begin
        idx_n = idx + 7'd1;
        if (idx == 7'(FRAME_WORDS - 1)) state_n = COLLECT;
      end
      FIN: state_n = IDLE;
      default: state_n = state;
    endcase
    if (last || tmo) state_n = FIN;
  end
  // stream outputs follow the next state so they change on the same edge as the FSM
  always_comb begin
    fv_d = state_n == FILTER;
    iv_d = state_n == IMAGE;
    data_d = (fv_d || iv_d) ? fbuf[idx_n] : 4'd0;
  end
  conv_tx_result_bank u_bank (
    .clk(clk), .rst_n(rst_n), .clr(go), .we(cap), .waddr(beat[3:0]),
    .wdata(s.out_data), .raddr(rd_addr), .rdata(rd_data)
  );
`ifdef CONV_TX_TIMEOUT_EN
  logic [TCNT_W-1:0] tcnt;
  logic terr, run;
  assign run = state == FILTER || state == IMAGE || state == COLLECT;
  assign tmo = run && tcnt == TCNT_W'(TIMEOUT - 1) && !last;
  assign timeout_err = terr;
  // cycles since the accepted start; abort fires on the TIMEOUT-th edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      terr <= 1'b0;
    end else begin
      tcnt <= go ? '0 : tcnt + TCNT_W'(run);
      terr <= go ? 1'b0 : terr | tmo;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
